// File: rtl/reg_file_sb_pkg.sv
// Shared defaults and types for the parametrised register file with load scoreboard.
package reg_file_pkg;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_NUM_REGS = 8;
  localparam int DEF_ADDR_W   = $clog2(DEF_NUM_REGS);
  localparam int DEF_RS_W     = 2;

  typedef logic [DEF_DATA_W-1:0] data_t;
  typedef logic [DEF_ADDR_W-1:0] reg_idx_t;

  typedef enum logic {
    SB_IDLE = 1'b0,
    SB_PEND = 1'b1
  } sb_state_e;
endpackage

// File: rtl/reg_file_sb_if.sv
// Pipeline-side bus of the register file: decode reads, writeback ports and load handshake.
interface reg_file_sb_if
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int RS_W   = DEF_RS_W
) ();
  logic [RS_W-1:0]   rs;
  logic [ADDR_W-1:0] rt;
  logic [DATA_W-1:0] rs_val_o;
  logic [DATA_W-1:0] rt_val_o;
  logic              write_enable;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] write_data;
  logic              cout_write_enable;
  logic [DATA_W-1:0] cout_data;
  logic              ld_issue;
  logic [ADDR_W-1:0] ld_dest;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_busy_o;
  logic              hazard_o;

  modport master (
    output rs, rt, write_enable, wr_addr, write_data, cout_write_enable, cout_data,
           ld_issue, ld_dest, ld_valid, ld_data,
    input  rs_val_o, rt_val_o, ld_busy_o, hazard_o
  );

  modport slave (
    input  rs, rt, write_enable, wr_addr, write_data, cout_write_enable, cout_data,
           ld_issue, ld_dest, ld_valid, ld_data,
    output rs_val_o, rt_val_o, ld_busy_o, hazard_o
  );
endinterface

// File: rtl/reg_file_sb_ld_scoreboard.sv
// Single-entry load scoreboard: tracks one outstanding load and flags hazards against it.
//   state   | meaning
//   SB_IDLE | no load outstanding, ld_valid ignored
//   SB_PEND | load outstanding, pend_q holds its destination register
module ld_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int RS_W   = DEF_RS_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_issue_i,
  input  logic [ADDR_W-1:0] ld_dest_i,
  input  logic              ld_valid_i,
  input  logic [RS_W-1:0]   rs_i,
  input  logic [ADDR_W-1:0] rt_i,
  input  logic              write_enable_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  output logic              ld_busy_o,
  output logic [ADDR_W-1:0] pend_o,
  output logic              hazard_o
);
  sb_state_e         state_q;
  logic [ADDR_W-1:0] pend_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SB_IDLE;
      pend_q  <= '0;
    end else begin
      case (state_q)
        SB_IDLE: begin
          if (ld_issue_i) begin
            state_q <= SB_PEND;
            pend_q  <= ld_dest_i;
          end
        end
        SB_PEND: begin
          // a return with a fresh issue chains straight into the next load
          if (ld_valid_i) begin
            if (ld_issue_i) pend_q <= ld_dest_i;
            else            state_q <= SB_IDLE;
          end
        end
        default: state_q <= SB_IDLE;
      endcase
    end
  end

  assign ld_busy_o = (state_q == SB_PEND);
  assign pend_o    = pend_q;
  assign hazard_o  = ld_busy_o && ((ADDR_W'(rs_i) == pend_q) || (rt_i == pend_q) ||
                                   (write_enable_i && (wr_addr_i == pend_q)));

`ifndef SYNTHESIS
  a_no_issue_while_pend: assert property (@(posedge clk) disable iff (reset)
    (state_q == SB_PEND && ld_issue_i) |-> ld_valid_i)
    else $error("ld_issue while a load is already pending");
`endif
endmodule

// File: rtl/reg_file_sb.sv
// Parametrised two-read register file with carry port, optional write bypass and load writeback.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int RS_W     = DEF_RS_W,
  parameter int COUT_IDX = NUM_REGS - 1,
  parameter int BYPASS   = 1
) (
  input logic         clk,
  input logic         reset,
  reg_file_sb_if.slave bus
);
  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam logic [ADDR_W-1:0] COUT_ADDR = ADDR_W'(COUT_IDX);

  logic [DATA_W-1:0] rf_q [NUM_REGS];
  logic [DATA_W-1:0] rf_d [NUM_REGS];
  logic              ld_busy;
  logic [ADDR_W-1:0] ld_pend;
  logic              ld_wr_en;
  logic [ADDR_W-1:0] rs_addr;

  ld_scoreboard #(.ADDR_W(ADDR_W), .RS_W(RS_W)) u_sb (
    .clk            (clk),
    .reset          (reset),
    .ld_issue_i     (bus.ld_issue),
    .ld_dest_i      (bus.ld_dest),
    .ld_valid_i     (bus.ld_valid),
    .rs_i           (bus.rs),
    .rt_i           (bus.rt),
    .write_enable_i (bus.write_enable),
    .wr_addr_i      (bus.wr_addr),
    .ld_busy_o      (ld_busy),
    .pend_o         (ld_pend),
    .hazard_o       (bus.hazard_o)
  );

  assign ld_wr_en = bus.ld_valid && ld_busy;

  // later assignments win: load < cout < primary
  always_comb begin
    rf_d = rf_q;
    if (!reset) begin
      if (ld_wr_en)              rf_d[ld_pend]   = bus.ld_data;
      if (bus.cout_write_enable) rf_d[COUT_ADDR] = bus.cout_data;
      if (bus.write_enable)      rf_d[bus.wr_addr] = bus.write_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else begin
      rf_q <= rf_d;
    end
  end

  assign rs_addr = ADDR_W'(bus.rs);

  generate
    if (BYPASS != 0) begin : g_bypass
      assign bus.rs_val_o = rf_d[rs_addr];
      assign bus.rt_val_o = rf_d[bus.rt];
    end else begin : g_no_bypass
      assign bus.rs_val_o = rf_q[rs_addr];
      assign bus.rt_val_o = rf_q[bus.rt];
    end
  endgenerate

  assign bus.ld_busy_o = ld_busy;
endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: bypass and non-bypass instances share stimulus and one reference model.
module tb_reg_file_sb;
  import reg_file_pkg::*;

  localparam int NR = 8;
  localparam int CI = NR - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0] rs;
  reg_idx_t   rt, wr_addr, ld_dest;
  data_t      write_data, cout_data, ld_data;
  logic       write_enable, cout_write_enable, ld_issue, ld_valid;

  reg_file_sb_if bus1 ();
  reg_file_sb_if bus0 ();

  assign bus1.rs = rs;                 assign bus0.rs = rs;
  assign bus1.rt = rt;                 assign bus0.rt = rt;
  assign bus1.write_enable = write_enable;           assign bus0.write_enable = write_enable;
  assign bus1.wr_addr = wr_addr;                     assign bus0.wr_addr = wr_addr;
  assign bus1.write_data = write_data;               assign bus0.write_data = write_data;
  assign bus1.cout_write_enable = cout_write_enable; assign bus0.cout_write_enable = cout_write_enable;
  assign bus1.cout_data = cout_data;                 assign bus0.cout_data = cout_data;
  assign bus1.ld_issue = ld_issue;                   assign bus0.ld_issue = ld_issue;
  assign bus1.ld_dest = ld_dest;                     assign bus0.ld_dest = ld_dest;
  assign bus1.ld_valid = ld_valid;                   assign bus0.ld_valid = ld_valid;
  assign bus1.ld_data = ld_data;                     assign bus0.ld_data = ld_data;

  reg_file_sb #(.BYPASS(1)) u_byp   (.clk(clk), .reset(reset), .bus(bus1.slave));
  reg_file_sb #(.BYPASS(0)) u_nobyp (.clk(clk), .reset(reset), .bus(bus0.slave));

  data_t    m_rf [NR];
  bit       m_busy;
  reg_idx_t m_pend;
  int       n_vec = 0;
  int       n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h @%0t", tag, act, exp, $time);
    end
  endtask

  // value seen by a reader: stored value, overwritten by each active writer in rising priority
  function automatic data_t exp_read(input reg_idx_t a, input bit byp);
    data_t d = m_rf[a];
    if (byp && !reset) begin
      if (m_busy && ld_valid && m_pend == a) d = ld_data;
      if (cout_write_enable && a == reg_idx_t'(CI)) d = cout_data;
      if (write_enable && wr_addr == a) d = write_data;
    end
    return d;
  endfunction

  function automatic bit exp_hazard();
    return m_busy && ((reg_idx_t'(rs) == m_pend) || (rt == m_pend) ||
                      (write_enable && wr_addr == m_pend));
  endfunction

  task automatic check_all();
    chk("byp_rs",   bus1.rs_val_o,  exp_read(reg_idx_t'(rs), 1'b1));
    chk("byp_rt",   bus1.rt_val_o,  exp_read(rt, 1'b1));
    chk("nobyp_rs", bus0.rs_val_o,  exp_read(reg_idx_t'(rs), 1'b0));
    chk("nobyp_rt", bus0.rt_val_o,  exp_read(rt, 1'b0));
    chk("busy",     {31'd0, bus1.ld_busy_o}, {31'd0, m_busy});
    chk("busy_nb",  {31'd0, bus0.ld_busy_o}, {31'd0, m_busy});
    chk("hazard",   {31'd0, bus1.hazard_o},  {31'd0, exp_hazard()});
    chk("hazard_nb",{31'd0, bus0.hazard_o},  {31'd0, exp_hazard()});
  endtask

  task automatic idle();
    write_enable = 0; cout_write_enable = 0; ld_issue = 0; ld_valid = 0;
  endtask

  // inputs are already driven; check mid-cycle, then advance one clock and the model with it
  task automatic cycle();
    data_t    nrf [NR];
    bit       nbusy;
    reg_idx_t npend;
    #1;
    check_all();
    nrf = m_rf;
    nbusy = m_busy;
    npend = m_pend;
    if (m_busy && ld_valid) nrf[m_pend] = ld_data;
    if (cout_write_enable) nrf[CI] = cout_data;
    if (write_enable) nrf[wr_addr] = write_data;
    if (!m_busy && ld_issue) begin
      nbusy = 1; npend = ld_dest;
    end else if (m_busy && ld_valid) begin
      nbusy = ld_issue;
      if (ld_issue) npend = ld_dest;
    end
    @(posedge clk);
    m_rf = nrf; m_busy = nbusy; m_pend = npend;
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    for (int i = 0; i < NR; i++) m_rf[i] = '0;
    m_busy = 0; m_pend = '0;
    #1;
    check_all();
    @(posedge clk); #1;
    check_all();
    reset = 0;
  endtask

  task automatic wr(input reg_idx_t a, input data_t d);
    idle(); write_enable = 1; wr_addr = a; write_data = d;
    cycle();
  endtask

  initial begin
    reset = 0; rs = 0; rt = 0; wr_addr = 0; ld_dest = 0;
    write_data = 0; cout_data = 0; ld_data = 0;
    idle();
    #2;
    do_reset();

    // reset mid-run clears stored data immediately
    wr(3, 8'h55);
    rs = 2'd3; rt = 3; idle(); cycle();
    chk("rf3_55", bus0.rt_val_o, 8'h55);
    @(negedge clk);
    do_reset();
    chk("rst_rs", bus1.rs_val_o, 8'h00);

    // same-cycle bypass vs pre-edge read
    idle(); write_enable = 1; wr_addr = 5; write_data = 8'hA7; rt = 5;
    #1; chk("tp_byp_a7", bus1.rt_val_o, 8'hA7); chk("tp_nobyp_old", bus0.rt_val_o, 8'h00);
    cycle();
    idle(); cycle();
    chk("tp_after_a7", bus0.rt_val_o, 8'hA7);

    // primary beats cout on the carry register
    idle(); cout_write_enable = 1; cout_data = 8'h01;
    write_enable = 1; wr_addr = 7; write_data = 8'h80; rt = 7;
    cycle();
    idle(); cycle();
    chk("tp_prim_wins", bus0.rt_val_o, 8'h80);
    idle(); cout_write_enable = 1; cout_data = 8'h01; cycle();
    idle(); cycle();
    chk("tp_cout_only", bus0.rt_val_o, 8'h01);

    // rs is zero-extended, not aliased onto the top register
    wr(3, 8'h3C); wr(7, 8'hFF);
    idle(); rs = 2'b11; cycle();
    chk("tp_rs_zext", bus0.rs_val_o, 8'h3C);

    // single load round trip
    idle(); rs = 0; ld_issue = 1; ld_dest = 2; cycle();
    idle(); rt = 2;
    repeat (3) begin
      cycle();
      chk("tp_ld_haz", {31'd0, bus1.hazard_o}, 32'd1);
    end
    ld_valid = 1; ld_data = 8'h9E; cycle();
    idle(); cycle();
    chk("tp_ld_ret", bus0.rt_val_o, 8'h9E);
    chk("tp_ld_idle", {31'd0, bus0.ld_busy_o}, 32'd0);

    // back-to-back load, then reset discards the second one
    idle(); ld_issue = 1; ld_dest = 4; cycle();
    idle(); ld_valid = 1; ld_data = 8'h11; ld_issue = 1; ld_dest = 6; cycle();
    idle(); rt = 4; rs = 0; cycle();
    chk("tp_b2b_data", bus0.rt_val_o, 8'h11);
    rt = 6; #1;
    chk("tp_b2b_haz", {31'd0, bus0.hazard_o}, 32'd1);
    @(negedge clk);
    do_reset();
    idle(); ld_valid = 1; ld_data = 8'h22; cycle();
    idle(); cycle();
    chk("tp_discard", bus0.rt_val_o, 8'h00);

    // random traffic within the load protocol
    for (int it = 0; it < 600; it++) begin
      if (it % 200 == 199) begin
        @(negedge clk);
        do_reset();
      end
      rs = 2'($urandom_range(0, 3));
      rt = reg_idx_t'($urandom_range(0, NR - 1));
      write_enable = ($urandom_range(0, 2) == 0);
      wr_addr = reg_idx_t'($urandom_range(0, NR - 1));
      write_data = data_t'($urandom);
      cout_write_enable = ($urandom_range(0, 3) == 0);
      cout_data = data_t'($urandom);
      ld_valid = ($urandom_range(0, 2) == 0);
      ld_data = data_t'($urandom);
      ld_issue = ($urandom_range(0, 2) == 0) && (!m_busy || ld_valid);
      ld_dest = reg_idx_t'($urandom_range(0, NR - 1));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
